monkey_motion_fsm: RTL

- Per-frame motion controller for the player monkey.
- Latches collision, ladder, keypad and jump events across a frame and runs a movement-mode FSM (IDLE/GROUNDED/JUMP/FALL/CLIMB/DEAD) on each startOfFrame.
- Outputs registered signed X/Y speed commands (1/64-pixel units per frame) and an update strobe to the downstream position integrator, which only accumulates them.

---
 rtl/monkey_motion_pkg.sv | 69 ++++++
 rtl/monkey_motion_if.sv | 13 +
 rtl/monkey_motion_fsm_event_latch.sv | 50 +++++
 rtl/monkey_motion_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/monkey_motion_pkg.sv
// Shared types and constants for the monkey motion controller: states, edge bits,
// keypad codes, speed constants and the saturating speed adder.
package monkey_motion_pkg;

  localparam int unsigned SPD_W         = 11;
  localparam int unsigned SUM_W         = 12;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned EDGE_W        = 4;
  localparam int unsigned STATE_W       = 3;
  localparam int unsigned DEATH_FRAMES  = 60;
  localparam int unsigned DCNT_W        = $clog2(DEATH_FRAMES);
  localparam int unsigned COY_W         = 3;
  localparam int unsigned COYOTE_FRAMES = 4;

  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  localparam logic [DIGIT_W-1:0] DIGIT_LEFT  = 4'd4;
  localparam logic [DIGIT_W-1:0] DIGIT_RIGHT = 4'd6;
  localparam logic [DIGIT_W-1:0] DIGIT_UP    = 4'd8;
  localparam logic [DIGIT_W-1:0] DIGIT_DOWN  = 4'd2;

  // Speeds in 1/64 pixel per frame; positive Y is downward
  localparam logic signed [SPD_W-1:0] X_SPEED        = 11'sd40;
  localparam logic signed [SPD_W-1:0] JUMP_SPEED     = -11'sd300;
  localparam logic signed [SPD_W-1:0] GRAVITY        = 11'sd5;
  localparam logic signed [SPD_W-1:0] MAX_FALL_SPEED = 11'sd230;
  localparam logic signed [SPD_W-1:0] CEIL_BOUNCE    = 11'sd10;
  localparam logic signed [SPD_W-1:0] CLIMB_SPEED    = 11'sd32;
  localparam logic signed [SPD_W-1:0] SPD_SAT        = 11'sd1023;

  localparam logic signed [SUM_W-1:0] SUM_MAX = 12'sd1023;
  localparam logic signed [SUM_W-1:0] SUM_MIN = -12'sd1023;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_GROUNDED = 3'd1,
    ST_JUMP     = 3'd2,
    ST_FALL     = 3'd3,
    ST_CLIMB    = 3'd4,
    ST_DEAD     = 3'd5
  } state_e;

  typedef struct packed {
    logic floor_hit;
    logic ceil_hit;
    logic left_wall;
    logic right_wall;
    logic ladder;
    logic jump;
    logic death;
    logic key_up;
    logic key_down;
    logic key_left;
    logic key_right;
  } motion_flags_t;

  function automatic logic signed [SPD_W-1:0] sat_add(input logic signed [SPD_W-1:0] a,
                                                      input logic signed [SPD_W-1:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_MAX) return SPD_SAT;
    if (s < SUM_MIN) return -SPD_SAT;
    return s[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/monkey_motion_if.sv
// Speed command bus from the motion controller to the position integrator.
interface monkey_motion_if;
  import monkey_motion_pkg::*;

  logic signed [SPD_W-1:0]   Xspeed;
  logic signed [SPD_W-1:0]   Yspeed;
  logic                      posUpdateEn;
  logic        [STATE_W-1:0] monkeyState;
  logic                      deadDone;

  modport master (output Xspeed, Yspeed, posUpdateEn, monkeyState, deadDone);
  modport slave  (input  Xspeed, Yspeed, posUpdateEn, monkeyState, deadDone);
endinterface

// File: rtl/monkey_motion_fsm_event_latch.sv
// Sticky per-frame event flags; cleared on startOfFrame, with same-cycle events merged
// into the flags the FSM sees on that cycle.
module monkey_event_latch
  import monkey_motion_pkg::*;
(
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                jumpIsPressed,
  input  logic                digitIsPressed,
  input  logic [DIGIT_W-1:0]  digit,
  input  logic                wallCollision,
  input  logic                ladderCollision,
  input  logic [EDGE_W-1:0]   HitEdgeCode,
  input  logic                deathEvent,
  output motion_flags_t       flags_c
);

  motion_flags_t flags_q;
  motion_flags_t ev_c;

  // Corner hits (two perpendicular edges) are ambiguous and set no wall flag
  always_comb begin
    ev_c            = '0;
    ev_c.floor_hit  = wallCollision & HitEdgeCode[EDGE_BOTTOM]
                      & ~(HitEdgeCode[EDGE_LEFT] | HitEdgeCode[EDGE_RIGHT]);
    ev_c.ceil_hit   = wallCollision & HitEdgeCode[EDGE_TOP]
                      & ~(HitEdgeCode[EDGE_LEFT] | HitEdgeCode[EDGE_RIGHT]);
    ev_c.left_wall  = wallCollision & HitEdgeCode[EDGE_LEFT]
                      & ~(HitEdgeCode[EDGE_TOP] | HitEdgeCode[EDGE_BOTTOM]);
    ev_c.right_wall = wallCollision & HitEdgeCode[EDGE_RIGHT]
                      & ~(HitEdgeCode[EDGE_TOP] | HitEdgeCode[EDGE_BOTTOM]);
    ev_c.ladder     = ladderCollision;
    ev_c.jump       = jumpIsPressed;
    ev_c.death      = deathEvent;
    ev_c.key_up     = digitIsPressed & (digit == DIGIT_UP);
    ev_c.key_down   = digitIsPressed & (digit == DIGIT_DOWN);
    ev_c.key_left   = digitIsPressed & (digit == DIGIT_LEFT);
    ev_c.key_right  = digitIsPressed & (digit == DIGIT_RIGHT);
  end

  assign flags_c = motion_flags_t'(flags_q | ev_c);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           flags_q <= '0;
    else if (startOfFrame) flags_q <= '0;
    else                   flags_q <= flags_c;
  end

endmodule

// File: rtl/monkey_motion_fsm.sv
// Per-frame movement-mode FSM and speed datapath for the player monkey.
// Define MONKEY_COYOTE_JUMP_EN to allow a short jump grace window after walking off a ledge.
module monkey_motion_fsm
  import monkey_motion_pkg::*;
(
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                gameActive,
  input  logic                jumpIsPressed,
  input  logic                digitIsPressed,
  input  logic [DIGIT_W-1:0]  digit,
  input  logic                wallCollision,
  input  logic                ladderCollision,
  input  logic [EDGE_W-1:0]   HitEdgeCode,
  input  logic                deathEvent,
  monkey_motion_if.master     cmd
);

  motion_flags_t fl;

  monkey_event_latch u_event_latch (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .jumpIsPressed   (jumpIsPressed),
    .digitIsPressed  (digitIsPressed),
    .digit           (digit),
    .wallCollision   (wallCollision),
    .ladderCollision (ladderCollision),
    .HitEdgeCode     (HitEdgeCode),
    .deathEvent      (deathEvent),
    .flags_c         (fl)
  );

  state_e                  state_q, state_n;
  logic signed [SPD_W-1:0] xs_q, xs_n, ys_q, ys_n;
  logic signed [SPD_W-1:0] walk_x, climb_y, grav_y;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_n;
  logic                    pos_q, dd_q, dd_c;
`ifdef MONKEY_COYOTE_JUMP_EN
  logic [COY_W-1:0]        coy_q, coy_n;
`endif

  // Wall push-away beats keypad direction
  always_comb begin
    if (fl.left_wall)       walk_x = X_SPEED;
    else if (fl.right_wall) walk_x = -X_SPEED;
    else if (fl.key_left)   walk_x = -X_SPEED;
    else if (fl.key_right)  walk_x = X_SPEED;
    else                    walk_x = '0;
  end

  assign climb_y = fl.key_up ? -CLIMB_SPEED : (fl.key_down ? CLIMB_SPEED : '0);
  assign grav_y  = sat_add(ys_q, GRAVITY);

  always_comb begin
    state_n = state_q;
    xs_n    = xs_q;
    ys_n    = ys_q;
    dcnt_n  = dcnt_q;
    dd_c    = 1'b0;
`ifdef MONKEY_COYOTE_JUMP_EN
    coy_n   = coy_q;
`endif
    if (startOfFrame) begin
`ifdef MONKEY_COYOTE_JUMP_EN
      if (coy_q != '0) coy_n = coy_q - COY_W'(1);
`endif
      if (!gameActive) begin
        state_n = ST_IDLE;
        ys_n    = '0;
      end else if (fl.death && state_q != ST_DEAD) begin
        state_n = ST_DEAD;
        ys_n    = '0;
        dcnt_n  = DCNT_W'(DEATH_FRAMES - 1);
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_n = ST_FALL;
            ys_n    = '0;
          end
          ST_GROUNDED: begin
            ys_n = '0;
            if (fl.ladder && fl.key_up) begin
              state_n = ST_CLIMB;
              ys_n    = climb_y;
            end else if (fl.jump && fl.floor_hit) begin
              state_n = ST_JUMP;
              ys_n    = JUMP_SPEED;
            end else if (!fl.floor_hit) begin
              state_n = ST_FALL;
              ys_n    = GRAVITY;
`ifdef MONKEY_COYOTE_JUMP_EN
              coy_n   = COY_W'(COYOTE_FRAMES);
`endif
            end
          end
          ST_JUMP: begin
            if (fl.ceil_hit) begin
              state_n = ST_FALL;
              ys_n    = CEIL_BOUNCE;
            end else if (fl.ladder && fl.key_up) begin
              state_n = ST_CLIMB;
              ys_n    = climb_y;
            end else begin
              ys_n = grav_y;
              if (!grav_y[SPD_W-1]) state_n = ST_FALL;
            end
          end
          ST_FALL: begin
            if (fl.floor_hit) begin
              state_n = ST_GROUNDED;
              ys_n    = '0;
            end else if (fl.ladder && (fl.key_up || fl.key_down)) begin
              state_n = ST_CLIMB;
              ys_n    = climb_y;
`ifdef MONKEY_COYOTE_JUMP_EN
            end else if (fl.jump && coy_q != '0) begin
              state_n = ST_JUMP;
              ys_n    = JUMP_SPEED;
              coy_n   = '0;
`endif
            end else begin
              ys_n = (grav_y > MAX_FALL_SPEED) ? MAX_FALL_SPEED : grav_y;
            end
          end
          ST_CLIMB: begin
            ys_n = climb_y;
            if (!fl.ladder || fl.jump) begin
              state_n = ST_FALL;
              ys_n    = '0;
            end else if (fl.floor_hit && fl.key_down) begin
              state_n = ST_GROUNDED;
              ys_n    = '0;
            end
          end
          ST_DEAD: begin
            ys_n = '0;
            if (dcnt_q == '0) begin
              state_n = ST_IDLE;
              dd_c    = 1'b1;
            end else begin
              dcnt_n = dcnt_q - DCNT_W'(1);
            end
          end
          default: begin
            state_n = ST_IDLE;
            ys_n    = '0;
          end
        endcase
      end
      xs_n = (state_n inside {ST_IDLE, ST_DEAD, ST_CLIMB}) ? '0 : walk_x;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      dcnt_q  <= '0;
      pos_q   <= 1'b0;
      dd_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      xs_q    <= xs_n;
      ys_q    <= ys_n;
      dcnt_q  <= dcnt_n;
      pos_q   <= startOfFrame;
      dd_q    <= dd_c;
    end
  end

`ifdef MONKEY_COYOTE_JUMP_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) coy_q <= '0;
    else         coy_q <= coy_n;
  end
`endif

  assign cmd.Xspeed      = xs_q;
  assign cmd.Yspeed      = ys_q;
  assign cmd.posUpdateEn = pos_q;
  assign cmd.monkeyState = state_q;
  assign cmd.deadDone    = dd_q;

endmodule
